// File: rtl/button_debounce_ctrl.sv
// rtl/button_debounce_ctrl.sv - per-channel push-button synchroniser, debouncer and auto-repeat pulse generator
module button_debounce_ctrl #(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat
);

    localparam logic [N_CH-1:0]  RELEASED   = {N_CH{ACTIVE_LOW != 0}};
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_DELAY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_PERIOD = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam bit               RPT_EN     = (REPEAT_DELAY != 0);
    localparam bit               PERIOD_EN  = (REPEAT_PERIOD != 0);

    logic [N_CH-1:0]            sync1_q, sync1_d;
    logic [N_CH-1:0]            sync2_q, sync2_d;
    logic [N_CH-1:0]            s;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]            level_q, level_d;
    logic [N_CH-1:0]            press_q, press_d;
    logic [N_CH-1:0]            release_q, release_d;
    logic [N_CH-1:0][CNT_W-1:0] rcnt_q, rcnt_d;
    logic [N_CH-1:0]            fired_q, fired_d;
    logic [N_CH-1:0]            repeat_q, repeat_d;

    assign sync1_d = btn_raw;
    assign sync2_d = sync1_q;
    assign s       = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        rcnt_d    = rcnt_q;
        fired_d   = fired_q;
        repeat_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                level_d[i]   = s[i];
                cnt_d[i]     = '0;
                press_d[i]   = s[i];
                release_d[i] = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end

            // Repeat timing only runs while the key stays accepted across the edge,
            // so the press edge and the release edge both clear it.
            if (!(RPT_EN && level_q[i] && level_d[i])) begin
                rcnt_d[i]  = '0;
                fired_d[i] = 1'b0;
            end else if (!fired_q[i]) begin
                if (rcnt_q[i] + ONE == RPT_DELAY) begin
                    repeat_d[i] = 1'b1;
                    rcnt_d[i]   = '0;
                    fired_d[i]  = 1'b1;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + ONE;
                end
            end else if (PERIOD_EN) begin
                if (rcnt_q[i] + ONE == RPT_PERIOD) begin
                    repeat_d[i] = 1'b1;
                    rcnt_d[i]   = '0;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + ONE;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q   <= RELEASED;
            sync2_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            rcnt_q    <= '0;
            fired_q   <= '0;
            repeat_q  <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            rcnt_q    <= rcnt_d;
            fired_q   <= fired_d;
            repeat_q  <= repeat_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// tb/tb_button_debounce_ctrl.sv - directed-vector bench for button_debounce_ctrl
module tb_button_debounce_ctrl;

    logic       Clk     = 1'b0;
    logic       Reset   = 1'b1;
    logic [1:0] btn_raw = 2'b11;

    logic [1:0] lvl_a, prs_a, rel_a, rpt_a;
    logic [1:0] lvl_b, prs_b, rel_b, rpt_b;

    int n_vec = 0;
    int n_err = 0;
    int npress;

    button_debounce_ctrl #(
        .N_CH(2), .DEBOUNCE_CYCLES(4), .CNT_W(8), .ACTIVE_LOW(1),
        .REPEAT_DELAY(0), .REPEAT_PERIOD(0)
    ) u_dut (
        .Clk(Clk), .Reset(Reset), .btn_raw(btn_raw),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_repeat(rpt_a)
    );

    button_debounce_ctrl #(
        .N_CH(2), .DEBOUNCE_CYCLES(4), .CNT_W(8), .ACTIVE_LOW(1),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) u_rpt (
        .Clk(Clk), .Reset(Reset), .btn_raw(btn_raw),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_repeat(rpt_b)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic outs_a(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                          input logic [1:0] rel, input logic [1:0] rpt);
        chk({tag, ".level"},   32'(lvl_a), 32'(lvl));
        chk({tag, ".press"},   32'(prs_a), 32'(prs));
        chk({tag, ".release"}, 32'(rel_a), 32'(rel));
        chk({tag, ".repeat"},  32'(rpt_a), 32'(rpt));
    endtask

    task automatic outs_b(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                          input logic [1:0] rel, input logic [1:0] rpt);
        chk({tag, ".rlevel"},   32'(lvl_b), 32'(lvl));
        chk({tag, ".rpress"},   32'(prs_b), 32'(prs));
        chk({tag, ".rrelease"}, 32'(rel_b), 32'(rel));
        chk({tag, ".rrepeat"},  32'(rpt_b), 32'(rpt));
    endtask

    initial begin
        // reset state
        tick();
        tick();
        outs_a("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        outs_b("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs_a("idle", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // press ch0: accepted on the 6th edge after the raw change
        btn_raw = 2'b10;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 6) outs_a("press_wait", 2'b00, 2'b00, 2'b00, 2'b00);
            else       outs_a("press_edge", 2'b01, 2'b01, 2'b00, 2'b00);
        end
        tick();
        outs_a("press_after", 2'b01, 2'b00, 2'b00, 2'b00);

        // release ch0
        btn_raw = 2'b11;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("release_rpt_b", 32'(rpt_b), 32'(0));
            if (i < 6) outs_a("release_wait", 2'b01, 2'b00, 2'b00, 2'b00);
            else       outs_a("release_edge", 2'b00, 2'b00, 2'b01, 2'b00);
        end
        tick();
        outs_a("release_after", 2'b00, 2'b00, 2'b00, 2'b00);

        // bounce: 2-cycle segments never reach the 4-sample threshold
        for (int t = 0; t < 20; t++) begin
            if (t % 2 == 0) btn_raw[0] = ((t / 2) % 2 == 1);
            tick();
            chk("bounce_press", 32'(prs_a), 32'(0));
            chk("bounce_level", 32'(lvl_a), 32'(0));
        end
        btn_raw[0] = 1'b0;
        npress = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (prs_a[0]) npress++;
            if (i == 6) chk("bounce_press6", 32'(prs_a), 32'(2'b01));
        end
        chk("bounce_count", 32'(npress), 32'(1));

        // reset while held: outputs clear, key re-accepted after full latency
        Reset = 1'b1;
        tick();
        outs_a("rst_mid", 2'b00, 2'b00, 2'b00, 2'b00);
        outs_b("rst_mid", 2'b00, 2'b00, 2'b00, 2'b00);
        Reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 6) outs_a("rst_wait", 2'b00, 2'b00, 2'b00, 2'b00);
            else begin
                outs_a("rst_repress", 2'b01, 2'b01, 2'b00, 2'b00);
                outs_b("rst_repress", 2'b01, 2'b01, 2'b00, 2'b00);
            end
        end

        // auto-repeat at +8,+11,...; release accepted at +26 suppresses that slot
        for (int t = 1; t <= 30; t++) begin
            tick();
            chk("rpt_b0", 32'(rpt_b[0]), 32'(t >= 8 && (t - 8) % 3 == 0 && t < 26));
            chk("rpt_rel_b0", 32'(rel_b[0]), 32'(t == 26));
            chk("rpt_lvl_b0", 32'(lvl_b[0]), 32'(t < 26));
            chk("rpt_press_b", 32'(prs_b), 32'(0));
            chk("rpt_a_off", 32'(rpt_a), 32'(0));
            if (t == 20) btn_raw[0] = 1'b1;
        end

        // both channels pressed together, then ch1 released alone
        btn_raw = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 6) chk("both_wait", 32'(prs_a), 32'(0));
            else       outs_a("both_press", 2'b11, 2'b11, 2'b00, 2'b00);
        end
        tick();
        tick();
        btn_raw = 2'b10;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 6) outs_a("ch1_rel_wait", 2'b11, 2'b00, 2'b00, 2'b00);
            else       outs_a("ch1_rel_edge", 2'b01, 2'b00, 2'b10, 2'b00);
        end
        tick();
        outs_a("ch1_rel_after", 2'b01, 2'b00, 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
